// File: rtl/ex_mem_pkg.sv
// Shared types for the execute-to-memory stage: payload layout, control bit
// positions, funct3 size codes and skid-buffer state encodings.
package ex_mem_pkg;

  localparam int EX_MEM_XLEN = 32;

  // Bit positions inside the 4-bit control field carried to the memory stage
  localparam int CTL_MEM_TO_REG = 0;
  localparam int CTL_REG_WRITE  = 1;
  localparam int CTL_MEM_WRITE  = 2;
  localparam int CTL_MEM_READ   = 3;

  // funct3[1:0] access-size codes for loads and stores
  localparam logic [1:0] F3_SIZE_B = 2'b00;
  localparam logic [1:0] F3_SIZE_H = 2'b01;
  localparam logic [1:0] F3_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [EX_MEM_XLEN-1:0] result;
    logic [EX_MEM_XLEN-1:0] addr;
    logic [EX_MEM_XLEN-1:0] store_data;
    logic [4:0]             rd;
    logic [3:0]             ctl;
    logic [2:0]             funct3;
    logic                   misaligned;
  } ex_mem_payload_t;

  function automatic logic addr_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == F3_SIZE_H) bad = addr_lo[0];
    if (size == F3_SIZE_W) bad = |addr_lo;
    return bad;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready comes straight from a flop,
// so downstream backpressure never reaches the producer combinationally.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_e       state_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             accept;
  logic             drain;

  assign accept = in_valid && in_ready_reg && !flush;
  assign drain  = out_valid_reg && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= BUF_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      skid_data_reg <= '0;
    end else if (flush) begin
      state_reg     <= BUF_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        BUF_EMPTY: begin
          if (accept) begin
            out_data_reg  <= in_data;
            out_valid_reg <= 1'b1;
            state_reg     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && !drain) begin
            // Output is stalled: park the new entry and stop accepting
            skid_data_reg <= in_data;
            in_ready_reg  <= 1'b0;
            state_reg     <= BUF_TWO;
          end else if (accept) begin
            out_data_reg <= in_data;
          end else if (drain) begin
            out_valid_reg <= 1'b0;
            state_reg     <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (drain) begin
            out_data_reg <= skid_data_reg;
            in_ready_reg <= 1'b1;
            state_reg    <= BUF_ONE;
          end
        end
        default: begin
          state_reg     <= BUF_EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: rtl/ex_mem_pipe.sv
// RV32I execute-to-memory stage: link-value mux, misalignment check and branch
// redirect around a skid buffer. Optional trap masking: EX_MEM_MISALIGN_TRAP_EN.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_out,
  input  logic            branch_enable,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            mem_to_reg,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_addr,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_ctl,
  output logic [2:0]      out_funct3,
  output logic            out_misaligned,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

  ex_mem_payload_t payload_in;
  ex_mem_payload_t payload_out;
  logic [3:0]      ctl_raw;
  logic [3:0]      ctl_fwd;
  logic            misaligned;
  logic            accept;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            redirect_valid_reg;
  logic [XLEN-1:0] redirect_pc_reg;

  assign accept  = in_valid && in_ready && !flush;
  assign ctl_raw = {mem_read, mem_write, reg_write, mem_to_reg};

`ifdef EX_MEM_MISALIGN_TRAP_EN
  logic is_mem;
  assign is_mem     = mem_read || mem_write;
  assign misaligned = is_mem && addr_misaligned(funct3[1:0], alu_out[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned access still travels down the pipe but must not touch memory
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ctl
      if (gi == CTL_MEM_READ || gi == CTL_MEM_WRITE) begin : g_mem
        assign ctl_fwd[gi] = ctl_raw[gi] & ~misaligned;
      end else begin : g_pass
        assign ctl_fwd[gi] = ctl_raw[gi];
      end
    end
  endgenerate

  assign payload_in.result     = (is_jal || is_jalr) ? pc + 32'd4 : alu_out;
  assign payload_in.addr       = alu_out;
  assign payload_in.store_data = rs2_data;
  assign payload_in.rd         = rd;
  assign payload_in.ctl        = ctl_fwd;
  assign payload_in.funct3     = funct3;
  assign payload_in.misaligned = misaligned;

  pipe_skid_buf #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (payload_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (payload_out)
  );

  assign taken  = (is_branch && branch_enable) || is_jal || is_jalr;
  assign target = is_jalr ? {alu_out[XLEN-1:1], 1'b0} : pc + imm;

  // Redirect fires once per accepted taken transfer, regardless of drain timing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else if (flush) begin
      redirect_valid_reg <= 1'b0;
    end else begin
      redirect_valid_reg <= accept && taken;
      if (accept && taken) begin
        redirect_pc_reg <= target;
      end
    end
  end

  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

  assign out_result     = payload_out.result;
  assign out_addr       = payload_out.addr;
  assign out_store_data = payload_out.store_data;
  assign out_rd         = payload_out.rd;
  assign out_ctl        = payload_out.ctl;
  assign out_funct3     = payload_out.funct3;
  assign out_misaligned = payload_out.misaligned;

endmodule
